// File: rtl/cpu_ctrl_if.sv
// Controller-to-datapath bus: instruction-memory read port plus ALU operand/result lanes.
// The controller drives the master side; imem and ALU models sit on the slave side.
interface cpu_ctrl_if;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  alu_func;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags;

  modport master (
    output imem_en, imem_addr, alu_func, alu_a, alu_b,
    input  imem_rdata, alu_result, alu_flags
  );

  modport slave (
    input  imem_en, imem_addr, alu_func, alu_a, alu_b,
    output imem_rdata, alu_result, alu_flags
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/WB, 4 cycles per instruction, owns PC and 4x8 regfile.
// No backpressure: imem must return data the cycle after imem_en; the ALU is purely combinational.
module cpu_ctrl #(
  parameter logic [7:0] START_PC = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        halted,
  output logic        retire,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data,
  cpu_ctrl_if.master  bus
);

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] MUL  = 4'd2;
  localparam logic [3:0] DIV  = 4'd3;
  localparam logic [3:0] LDI  = 4'd4;
  localparam logic [3:0] BNE  = 4'd5;
  localparam logic [3:0] BEQ  = 4'd6;
  localparam logic [3:0] MOV  = 4'd7;
  localparam logic [3:0] HALT = 4'd15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t      state, nxt;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [7:0]  rf [4];
  logic [7:0]  res;
  logic [3:0]  flg;

  logic [3:0]  op;
  logic [1:0]  rd, rs;
  logic [7:0]  imm;

  logic        en_c;
  logic [3:0]  func_c;
  logic [7:0]  a_c, b_c;

  assign op  = ir[15:12];
  assign rd  = ir[11:10];
  assign rs  = ir[9:8];
  assign imm = ir[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= START_PC;
      ir    <= 16'd0;
      res   <= 8'd0;
      flg   <= 4'd0;
      for (int i = 0; i < 4; i++) rf[i] <= 8'd0;
    end else begin
      state <= nxt;
      case (state)
        IDLE, HALTED: if (start) pc <= START_PC;
        DECODE:       ir <= bus.imem_rdata;
        EXEC: begin
          res <= bus.alu_result;
          flg <= bus.alu_flags;
        end
        WB: begin
          case (op)
            ADD, SUB, MUL, DIV, LDI, MOV: begin
              rf[rd] <= res;
              pc     <= pc + 8'd1;
            end
            // flags==0 means the ALU found the branch condition true
            BNE, BEQ: pc <= (flg == 4'd0) ? imm : pc + 8'd1;
            HALT:     pc <= pc;
            default:  pc <= pc + 8'd1;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt    = state;
    en_c   = 1'b0;
    func_c = HALT;
    a_c    = 8'd0;
    b_c    = 8'd0;
    retire = 1'b0;
    case (state)
      IDLE:   if (start) nxt = FETCH;
      FETCH: begin
        en_c = 1'b1;
        nxt  = DECODE;
      end
      DECODE: nxt = EXEC;
      EXEC: begin
        nxt = WB;
        case (op)
          ADD, SUB, MUL, DIV, BNE, BEQ: begin
            func_c = op;
            a_c    = rf[rd];
            b_c    = rf[rs];
          end
          LDI: begin
            func_c = LDI;
            b_c    = imm;
          end
          MOV: begin
            func_c = MOV;
            b_c    = rf[rs];
          end
          default: ;
        endcase
      end
      WB: begin
        retire = 1'b1;
        nxt    = (op == HALT) ? HALTED : FETCH;
      end
      HALTED: if (start) nxt = FETCH;
      default: nxt = IDLE;
    endcase
  end

  assign busy          = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
  assign halted        = (state == HALTED);
  assign dbg_data      = rf[dbg_sel];
  assign bus.imem_en   = en_c;
  assign bus.imem_addr = pc;
  assign bus.alu_func  = func_c;
  assign bus.alu_a     = a_c;
  assign bus.alu_b     = b_c;

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit for the 8-bit CPU. It fetches 16-bit instructions from a synchronous instruction memory and decodes them. It sequences the combinational ALU by driving its func/operand inputs and capturing its result and flags. It owns the 4×8 register file and the program counter, and resolves BNE/BEQ branches from the ALU flags.

## Interface
Parameters:
- START_PC, 8'd0, PC value loaded on reset and on every start.
- Opcode constants ADD=0, SUB=1, MUL=2, DIV=3, LDI=4, BNE=5, BEQ=6, MOV=7, HALT=15. These are identical to the ALU func encoding; 15 is the ALU's NA code.

Ports:
- clk, input, 1, the single clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begins execution from START_PC. Sampled only in IDLE or HALTED.
- busy, output, 1, high in FETCH/DECODE/EXEC/WB.
- halted, output, 1, high in HALTED.
- retire, output, 1, one-cycle pulse in WB for every completed instruction, including HALT.
- imem_en, output, 1, read strobe.
- imem_addr, output, 8, read address, always equal to the PC.
- imem_rdata, input, 16, instruction word, valid the cycle after imem_en.
- alu_func, output, 4, to the ALU func input.
- alu_a, output, 8, to ALU a.
- alu_b, output, 8, to ALU b.
- alu_result, input, 8, from the ALU.
- alu_flags, input, 4, from the ALU. 0 means the branch condition holds.
- dbg_sel, input, 2, register-file debug select.
- dbg_data, output, 8, combinational R[dbg_sel].

## Operation
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- FSM states and transitions:
  - IDLE: start → FETCH.
  - FETCH: → DECODE.
  - DECODE: → EXEC.
  - EXEC: → WB.
  - WB: → FETCH, or → HALTED if op==HALT.
  - HALTED: start → FETCH.
- FETCH: imem_en=1; imem_addr=PC.
- DECODE: latch imem_rdata into IR.
- EXEC: drive the ALU from IR, then register alu_result and alu_flags at the cycle end.
  - ADD/SUB/MUL/DIV: func=op, a=R[rd], b=R[rs].
  - LDI: func=LDI, a=0, b=imm.
  - MOV: func=MOV, a=0, b=R[rs].
  - BNE/BEQ: func=op, a=R[rd], b=R[rs].
  - HALT and undefined ops 8–14: func=15, a=b=0.
- WB:
  - ADD/SUB/MUL/DIV/LDI/MOV: R[rd] ← registered result; PC ← PC+1.
  - BNE/BEQ: no register write. If registered flags==0, PC ← imm; otherwise PC ← PC+1.
  - Undefined ops: NOP; PC ← PC+1.
  - HALT: no register write and PC unchanged.
- Outside EXEC: alu_func=15, alu_a=alu_b=0.
- Arithmetic is the ALU's business: results are 8-bit truncated, signed, and DIV by 0 gives 0. The controller never checks the divisor.
- PC arithmetic is 8-bit modulo, so 255+1 wraps to 0.
- start behaviour:
  - Ignored while busy.
  - In HALTED: PC ← START_PC and registers are retained.
  - In IDLE after reset: registers are 0.
- rst in any state, including mid-instruction: next cycle is IDLE, PC=START_PC, R0–R3=0, IR=0. The in-flight instruction is discarded with no register write.

## Timing
- Reset values: busy=0, halted=0, retire=0, imem_en=0, imem_addr=START_PC, alu_func=15, alu_a=0, alu_b=0, dbg_data=0.
- start high at edge N in IDLE → FETCH at cycle N+1 (imem_en=1).
- Every instruction takes exactly 4 cycles: FETCH, DECODE, EXEC, WB.
- retire is high in WB, cycle N+4 for the first instruction.
- A register written in WB is visible on dbg_data the following cycle.
- It is also visible to the next instruction's EXEC, which occurs 3 cycles later, so there is no hazard.
- Memory contract: imem_rdata is sampled only in DECODE, one cycle after imem_en.
- HALT: HALTED is entered the cycle after its WB; halted stays high until start or rst.
- start and rst in the same cycle: rst wins.

## Test plan
- Program LDI R0,5; LDI R1,3; ADD R0,R1; HALT → R0=8, R1=3, 4 retire pulses, halted after 16 cycles from the first FETCH.
- LDI R2,100; LDI R3,0; DIV R2,R3; MUL R2,R2 → R2 goes 0 after the DIV, then stays 0. Also check LDI R0,-20 (8'hEC); LDI R1,16; MUL R0,R1 → R0=8'hC0, signed truncation.
- Countdown loop:
  - Program: LDI R0,3; LDI R1,1; LDI R2,0; SUB R0,R1 @3; BNE R0,R2,3; HALT.
  - Expected: BNE taken twice then falls through; R0=0; retire count=10.
- BEQ with R0≠R1 → not taken, PC+1. BEQ with R0=R1, imm=8'h40 → imem_addr=8'h40 on the next FETCH.
- PC wrap: START_PC=8'hFE with NOPs at FE and FF → third fetch address is 8'h00.
- Assert rst during the EXEC of ADD R0,R1 → IDLE next cycle, R0 unchanged (0), no retire. Also: start pulses while busy have no effect, and start in HALTED restarts from START_PC with registers preserved.
